// File: rtl/mult_sequencer_pkg.sv
// Shared types and constants for the shift-add multiplier controller.
package mult_pkg;

  localparam int MUL_WIDTH = 32;
  localparam int MUL_ITERS = 32;
  localparam int CNT_W     = 5;

  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(MUL_ITERS - 1);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PREP = 3'd1,
    MUL  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

endpackage

// File: rtl/mult_sequencer_if.sv
// Core <-> multiplier handshake: request operands in, HI/LO and status out.
interface mult_sequencer_if
  import mult_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Pipeline side: issues multiplies, stalls on busy
  modport master (
    output start, is_signed, a, b,
    input  busy, done, hi, lo
  );

  // Multiplier side
  modport slave (
    input  start, is_signed, a, b,
    output busy, done, hi, lo
  );

endinterface

// File: rtl/mult_sequencer_fsm.sv
// Sequencing FSM: state register, 32-step iteration counter, busy/done decode.
module mult_sequencer_fsm
  import mult_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   i_start,
  output state_t o_state,
  output logic   o_busy,
  output logic   o_done
);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;

  // State register and iteration counter
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: clocked state uses <= so every register samples pre-edge values,
    // independent of statement order within or across blocks.
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == PREP) begin
        r_cnt <= '0;
      end else if (r_state == MUL) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state selection and status decode from the registered state
  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    w_next = r_state;
    o_busy = 1'b0;
    o_done = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = PREP;
      end
      PREP: begin
        o_busy = 1'b1;
        w_next = MUL;
      end
      MUL: begin
        o_busy = 1'b1;
        if (r_cnt == LAST_ITER) w_next = FIX;
      end
      FIX: begin
        o_busy = 1'b1;
        w_next = DONE;
      end
      DONE: begin
        o_done = 1'b1;
        w_next = i_start ? PREP : IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  assign o_state = r_state;

endmodule

// File: rtl/mult_sequencer.sv
// Multi-cycle 32x32->64 shift-add multiplier for mult/multu. One shared
// 33-bit adder is reused for operand negation, accumulation and result
// correction; HI/LO are loaded on the edge entering DONE.
module mult_sequencer
  import mult_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
)(
  input logic             clk,
  input logic             rst_n,
  mult_sequencer_if.slave bus
);

  state_t             w_state;
  logic               w_busy;
  logic               w_done;
  logic               w_take;

  logic [WIDTH-1:0]   r_a;       // |a|, already a magnitude once captured
  logic [WIDTH-1:0]   r_b;       // raw b, converted to |b| in PREP
  logic               r_b_neg;   // b needs negating in PREP
  logic               r_neg;     // final product must be negated
  logic [WIDTH:0]     r_acc;
  logic [WIDTH-1:0]   r_mplr;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic [WIDTH:0]     w_add_x;
  logic [WIDTH:0]     w_add_y;
  logic               w_add_cin;
  logic [WIDTH:0]     w_sum;
  logic [WIDTH:0]     w_acc_add;
  logic [WIDTH-1:0]   w_fix_hi;
  logic [2*WIDTH-1:0] w_product;

  mult_sequencer_fsm u_fsm (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start (bus.start),
    .o_state (w_state),
    .o_busy  (w_busy),
    .o_done  (w_done)
  );

  assign w_take = bus.start && ((w_state == IDLE) || (w_state == DONE));

  // Shared adder operand select. The adder is otherwise idle in IDLE/DONE,
  // so it forms |a| from the incoming operand as it is captured, leaving
  // PREP free to form |b|. FIX negates the low product half here; its carry
  // out (set only when the low half is zero) ripples into the high half.
  always_comb begin
    w_add_x   = '0;
    w_add_y   = '0;
    w_add_cin = 1'b0;
    case (w_state)
      IDLE, DONE: begin
        w_add_x   = {1'b0, ~bus.a};
        w_add_cin = 1'b1;
      end
      PREP: begin
        w_add_x   = {1'b0, ~r_b};
        w_add_cin = 1'b1;
      end
      MUL: begin
        w_add_x = r_acc;
        w_add_y = {1'b0, r_a};
      end
      FIX: begin
        w_add_x   = {1'b0, ~r_mplr};
        w_add_cin = 1'b1;
      end
      default: ;
    endcase
  end

  assign w_sum     = w_add_x + w_add_y + (WIDTH+1)'(w_add_cin);
  assign w_acc_add = r_mplr[0] ? w_sum : r_acc;
  assign w_fix_hi  = ~r_acc[WIDTH-1:0] + WIDTH'(w_sum[WIDTH]);
  assign w_product = r_neg ? {w_fix_hi, w_sum[WIDTH-1:0]}
                           : {r_acc[WIDTH-1:0], r_mplr};

  // Operand capture, shift-add datapath and HI/LO result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_b_neg <= 1'b0;
      r_neg   <= 1'b0;
      r_acc   <= '0;
      r_mplr  <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      case (w_state)
        IDLE, DONE: begin
          if (w_take) begin
            r_a     <= (bus.is_signed && bus.a[WIDTH-1]) ? w_sum[WIDTH-1:0] : bus.a;
            r_b     <= bus.b;
            r_b_neg <= bus.is_signed && bus.b[WIDTH-1];
            r_neg   <= bus.is_signed && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          end
        end
        PREP: begin
          r_acc  <= '0;
          r_mplr <= r_b_neg ? w_sum[WIDTH-1:0] : r_b;
        end
        MUL: begin
          r_acc  <= {1'b0, w_acc_add[WIDTH:1]};
          r_mplr <= {w_acc_add[0], r_mplr[WIDTH-1:1]};
        end
        FIX: begin
          r_hi <= w_product[2*WIDTH-1:WIDTH];
          r_lo <= w_product[WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: directed corner cases, handshake,
// reset, plus randomized operands against a plain-arithmetic product model.
module tb_mult_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  mult_sequencer_if bus ();

  mult_sequencer #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference product from ordinary 64-bit arithmetic
  function automatic logic [63:0] ref_mul(input logic s, input logic [31:0] x,
                                          input logic [31:0] y);
    longint sx, sy;
    if (s) begin
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      return 64'(sx * sy);
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  // Issue one multiply and wait for done. Returns cycles from start to done,
  // whether busy stayed high and HI/LO held their old value meanwhile.
  // p1/p2 name cycles in which a stray start pulse (with junk operands) is sent.
  task automatic do_mul(input logic s, input logic [31:0] x, input logic [31:0] y,
                        input bit now, input int p1, input int p2,
                        output int lat, output bit busy_ok, output bit hold_ok);
    logic [63:0] prev;
    if (!now) @(negedge clk);
    prev          = {bus.hi, bus.lo};
    bus.start     = 1'b1;
    bus.is_signed = s;
    bus.a         = x;
    bus.b         = y;
    @(negedge clk);
    bus.start = 1'b0;
    lat       = 1;
    busy_ok   = 1'b1;
    hold_ok   = 1'b1;
    while (!bus.done && lat < 100) begin
      if (!bus.busy) busy_ok = 1'b0;
      if ({bus.hi, bus.lo} !== prev) hold_ok = 1'b0;
      if (lat == p1 || lat == p2) begin
        bus.start     = 1'b1;
        bus.a         = $urandom;
        bus.b         = $urandom;
        bus.is_signed = ~s;
      end else begin
        bus.start = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start = 1'b0;
  endtask

  task automatic mul_and_check(input string tag, input logic s, input logic [31:0] x,
                               input logic [31:0] y, input logic [63:0] exp,
                               input bit now, input int p1, input int p2);
    int lat;
    bit bok, hok;
    do_mul(s, x, y, now, p1, p2, lat, bok, hok);
    check({tag, "_latency"}, 64'(lat), 64'd35);
    check({tag, "_busy_during"}, 64'(bok), 64'd1);
    check({tag, "_hilo_hold"}, 64'(hok), 64'd1);
    check({tag, "_done"}, 64'(bus.done), 64'd1);
    check({tag, "_busy_at_done"}, 64'(bus.busy), 64'd0);
    check({tag, "_product"}, {bus.hi, bus.lo}, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        s;
    logic [31:0] x, y;

    bus.start     = 1'b0;
    bus.is_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    rst_n         = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 64'(bus.busy), 64'd0);
    check("reset_done", 64'(bus.done), 64'd0);
    check("reset_hilo", {bus.hi, bus.lo}, 64'd0);
    rst_n = 1'b1;

    // Basic unsigned, then the done pulse must drop after one cycle
    mul_and_check("u_3x5", 1'b0, 32'd3, 32'd5, 64'h0000_0000_0000_000F, 1'b0, -1, -1);
    @(negedge clk);
    check("done_one_cycle", 64'(bus.done), 64'd0);

    mul_and_check("u_max", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                  64'hFFFF_FFFE_0000_0001, 1'b0, -1, -1);
    mul_and_check("s_m1x1", 1'b1, 32'hFFFF_FFFF, 32'h0000_0001,
                  64'hFFFF_FFFF_FFFF_FFFF, 1'b0, -1, -1);
    mul_and_check("u_m1x1", 1'b0, 32'hFFFF_FFFF, 32'h0000_0001,
                  64'h0000_0000_FFFF_FFFF, 1'b0, -1, -1);
    mul_and_check("s_min_min", 1'b1, 32'h8000_0000, 32'h8000_0000,
                  64'h4000_0000_0000_0000, 1'b0, -1, -1);
    mul_and_check("s_min_x1", 1'b1, 32'h8000_0000, 32'h0000_0001,
                  64'hFFFF_FFFF_8000_0000, 1'b0, -1, -1);
    mul_and_check("s_zero", 1'b1, 32'h0000_0000, 32'hFFFF_FFFF,
                  64'h0, 1'b0, -1, -1);

    // Stray start pulses during busy are ignored
    mul_and_check("stray_start", 1'b1, 32'hFFFF_FFFD, 32'h0000_0007,
                  64'hFFFF_FFFF_FFFF_FFEB, 1'b0, 5, 20);

    // Back-to-back: start issued in the DONE cycle
    mul_and_check("b2b_first", 1'b0, 32'd9, 32'd9, 64'd81, 1'b0, -1, -1);
    mul_and_check("b2b_7x6", 1'b0, 32'd7, 32'd6, 64'd42, 1'b1, -1, -1);

    // Asynchronous reset in the middle of MUL
    @(negedge clk);
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.a         = 32'd1234;
    bus.b         = 32'd5678;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (9) @(negedge clk);
    check("pre_reset_busy", 64'(bus.busy), 64'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_busy", 64'(bus.busy), 64'd0);
    check("async_rst_done", 64'(bus.done), 64'd0);
    check("async_rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_rst_idle_busy", 64'(bus.busy), 64'd0);
    check("post_rst_idle_done", 64'(bus.done), 64'd0);
    mul_and_check("rst_2x2", 1'b0, 32'd2, 32'd2, 64'd4, 1'b0, -1, -1);

    // Randomized operands, alternating isolated and back-to-back issue
    for (int i = 0; i < 12; i++) begin
      s = 1'($urandom_range(0, 1));
      x = $urandom;
      y = $urandom;
      if (i == 3) x = 32'h8000_0000;
      if (i == 7) y = 32'h0000_0000;
      mul_and_check($sformatf("rand%0d", i), s, x, y, ref_mul(s, x, y),
                    (i % 2) == 1, -1, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
